// File: rtl/pipe_skid_stage.sv
// One-deep pipeline register with an optional skid entry, flush squash and a
// saturating stall counter. out_* always present the main entry.
module pipe_skid_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int SKID_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;
    logic [CTRL_WIDTH-1:0]   skid_ctrl;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic                    in_fire;
    logic                    out_fire;
    logic                    load_main_in;
    logic                    load_main_skid;
    logic                    load_skid;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            // Registered ready breaks the combinational path from out_ready;
            // rst_n gating keeps it low while reset is held.
            logic rdy_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_next != SKID);
                end
            end

            assign in_ready = rdy_q & rst_n & ~flush;
        end else begin : g_pass
            assign in_ready = (~out_valid | out_ready) & ~flush;
        end
    endgenerate

    always_comb begin
        occupancy = 2'd0;
        case (state)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = FULL;
                end
            end
            FULL: begin
                if (out_fire && in_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = SKID;
                end
            end
            SKID: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = FULL;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Squash wins over every handshake in the same cycle.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                out_ctrl <= in_ctrl;
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_ctrl <= skid_ctrl;
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: skid instance (A), pass-through instance (B) and a
// 4-bit-counter skid instance (C) share stimulus and are checked against queue models.
module tb_pipe_skid_stage;

    localparam logic [31:0] BEAT_A = 32'hAAAA_0001;
    localparam logic [31:0] BEAT_B = 32'hBBBB_0002;
    localparam logic [31:0] BEAT_C = 32'hCCCC_0003;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush, cnt_clr;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [15:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
    logic [31:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]  a_occupancy, b_occupancy, c_occupancy;
    logic [15:0] a_stall_cnt, b_stall_cnt;
    logic [3:0]  c_stall_cnt;

    logic [47:0] qa[$];
    logic [47:0] qb[$];
    bit          za = 1'b1;
    bit          zb = 1'b1;
    int          cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int          vectors = 0, miscompares = 0, cyc = 0;

    logic [67:0] va, ea, ma, vb, eb, mb;
    logic [55:0] vc, ec, mc;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(a_occupancy), .stall_cnt(a_stall_cnt));

    pipe_skid_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt));

    pipe_skid_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(1), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(c_occupancy), .stall_cnt(c_stall_cnt));

    // Skid stage accepts whenever fewer than two beats are held.
    function automatic logic exp_rdy_a();
        return rst_n && !flush && (qa.size() < 2);
    endfunction

    // Pass-through stage accepts when empty or when the held beat leaves now.
    function automatic logic exp_rdy_b();
        return !flush && (qb.size() == 0 || out_ready);
    endfunction

    task automatic snap();
        va = {a_out_valid, a_in_ready, a_occupancy, a_stall_cnt, a_out_ctrl, a_out_data};
        ea = {(qa.size() != 0), exp_rdy_a(), 2'(qa.size()), 16'(cnt_a),
              (qa.size() != 0) ? qa[0] : 48'h0};
        ma = {20'hFFFFF, (qa.size() == 0 && !za) ? 48'h0 : {48{1'b1}}};
        vb = {b_out_valid, b_in_ready, b_occupancy, b_stall_cnt, b_out_ctrl, b_out_data};
        eb = {(qb.size() != 0), exp_rdy_b(), 2'(qb.size()), 16'(cnt_b),
              (qb.size() != 0) ? qb[0] : 48'h0};
        mb = {20'hFFFFF, (qb.size() == 0 && !zb) ? 48'h0 : {48{1'b1}}};
        vc = {c_out_valid, c_in_ready, c_occupancy, c_stall_cnt, c_out_ctrl, c_out_data};
        ec = {ea[67:64], 4'(cnt_c), ea[47:0]};
        mc = {8'hFF, ma[47:0]};
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl, input logic clr);
        rst_n = r; in_valid = v; in_ctrl = c; in_data = d;
        out_ready = ordy; flush = fl; cnt_clr = clr;
        #1;
        snap();
    endtask

    // Advance one clock edge and apply the same edge to the reference queues.
    task automatic tick();
        logic [47:0] beat;
        logic r, fl, clr, ia, ib, oa, ob, sa, sb;
        beat = {in_ctrl, in_data};
        r = rst_n; fl = flush; clr = cnt_clr;
        ia = in_valid && exp_rdy_a();
        ib = in_valid && exp_rdy_b();
        oa = (qa.size() != 0) && out_ready;
        ob = (qb.size() != 0) && out_ready;
        sa = (qa.size() != 0) && !out_ready;
        sb = (qb.size() != 0) && !out_ready;
        @(posedge clk);
        if (!r) begin
            qa.delete(); qb.delete(); za = 1'b1; zb = 1'b1;
            cnt_a = 0; cnt_b = 0; cnt_c = 0;
        end else begin
            if (clr) begin
                cnt_a = 0; cnt_b = 0; cnt_c = 0;
            end else begin
                if (sa && cnt_a < 65535) cnt_a++;
                if (sa && cnt_c < 15) cnt_c++;
                if (sb && cnt_b < 65535) cnt_b++;
            end
            if (fl) begin
                qa.delete(); qb.delete(); za = 1'b1; zb = 1'b1;
            end else begin
                if (oa) void'(qa.pop_front());
                if (ia) begin qa.push_back(beat); za = 1'b0; end
                if (ob) void'(qb.pop_front());
                if (ib) begin qb.push_back(beat); zb = 1'b0; end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        drive(0, 1, 16'($urandom), $urandom, 1, 1, 1);
        tick();
        drive(0, 1, 16'($urandom), $urandom, 0, 1, 0);
        tick();
        drive(0, 1, 16'hFFFF, $urandom, 0, 1, 1);
        vectors++;
        if (va !== 68'h0) begin
            miscompares++; $display("FAIL reset_a cyc=%0d got=%h want=0", cyc, va);
        end
        vectors++;
        if ((vb & mb) !== (eb & mb)) begin
            miscompares++; $display("FAIL reset_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
        end
        vectors++;
        if (vc !== 56'h0) begin
            miscompares++; $display("FAIL reset_c cyc=%0d got=%h want=0", cyc, vc);
        end
        tick();
        drive(1, 0, 16'h0, 32'h0, 0, 0, 0);
        vectors++;
        if (a_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_release_rdy cyc=%0d got=%b want=1", cyc, a_in_ready);
        end
        tick();
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) drive(1, 1, 16'($urandom), 32'(k), 1, 0, 0);
            else        drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL stream_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            vectors++;
            if ((vb & mb) !== (eb & mb)) begin
                miscompares++; $display("FAIL stream_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
            end
            if (k > 1) begin
                vectors++;
                if ({a_out_valid, a_occupancy, a_stall_cnt, a_out_data} !== {1'b1, 2'd1, 16'd0, 32'(k - 1)}) begin
                    miscompares++;
                    $display("FAIL stream_seq cyc=%0d got=%h want=%h", cyc,
                             {a_out_valid, a_occupancy, a_stall_cnt, a_out_data}, {1'b1, 2'd1, 16'd0, 32'(k - 1)});
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int s = 0; s < 9; s++) begin
            case (s)
                0:       drive(1, 0, 16'h0, 32'h0, 0, 0, 1);
                1:       drive(1, 1, 16'h00A1, BEAT_A, 0, 0, 0);
                2:       drive(1, 1, 16'h00B2, BEAT_B, 0, 0, 0);
                3, 4, 5: drive(1, 1, 16'h0C0C, BEAT_C, 0, 0, 0);
                default: drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            endcase
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL bp_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            vectors++;
            if ((vb & mb) !== (eb & mb)) begin
                miscompares++; $display("FAIL bp_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
            end
            if (s >= 3 && s <= 5) begin
                vectors++;
                if ({a_occupancy, a_in_ready, a_out_data} !== {2'd2, 1'b0, BEAT_A}) begin
                    miscompares++;
                    $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, {a_occupancy, a_in_ready, a_out_data}, {2'd2, 1'b0, BEAT_A});
                end
            end
            if (s == 6) begin
                vectors++;
                if ({a_out_valid, a_stall_cnt, a_out_data} !== {1'b1, 16'd4, BEAT_A}) begin
                    miscompares++;
                    $display("FAIL bp_first cyc=%0d got=%h want=%h", cyc, {a_out_valid, a_stall_cnt, a_out_data}, {1'b1, 16'd4, BEAT_A});
                end
            end
            if (s == 7) begin
                vectors++;
                if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 16'h00B2, BEAT_B}) begin
                    miscompares++;
                    $display("FAIL bp_second cyc=%0d got=%h want=%h", cyc, {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 16'h00B2, BEAT_B});
                end
            end
            if (s == 8) begin
                vectors++;
                if (a_out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL bp_drained cyc=%0d got=%b want=0", cyc, a_out_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       drive(1, 1, 16'h1111, 32'h1111_0000, 0, 0, 0);
                1:       drive(1, 1, 16'h2222, 32'h2222_0000, 0, 0, 0);
                2:       drive(1, 1, 16'hFFFF, 32'h3333_0000, 1, 1, 0);
                3:       drive(1, 0, 16'h0, 32'h0, 0, 0, 0);
                default: drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            endcase
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL flush_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            vectors++;
            if ((vb & mb) !== (eb & mb)) begin
                miscompares++; $display("FAIL flush_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
            end
            if (s == 2) begin
                vectors++;
                if ({a_occupancy, a_in_ready, b_in_ready} !== {2'd2, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL flush_rdy cyc=%0d got=%h want=%h", cyc, {a_occupancy, a_in_ready, b_in_ready}, {2'd2, 1'b0, 1'b0});
                end
            end
            if (s >= 3) begin
                vectors++;
                if ({a_out_valid, a_occupancy, a_out_ctrl, a_out_data, b_out_valid, b_out_ctrl, b_out_data} !== 100'h0) begin
                    miscompares++;
                    $display("FAIL flush_zero cyc=%0d got=%h want=0", cyc,
                             {a_out_valid, a_occupancy, a_out_ctrl, a_out_data, b_out_valid, b_out_ctrl, b_out_data});
                end
            end
            tick();
        end
    endtask

    task automatic test_skid_off();
        for (int s = 0; s < 17; s++) begin
            if (s < 15) drive(1, 1, 16'($urandom), $urandom, (s % 3) != 1, 0, 0);
            else        drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            vectors++;
            if ((vb & mb) !== (eb & mb)) begin
                miscompares++; $display("FAIL skidoff_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
            end
            vectors++;
            if (b_occupancy > 2'd1) begin
                miscompares++; $display("FAIL skidoff_occ cyc=%0d got=%0d want<=1", cyc, b_occupancy);
            end
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL skidoff_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            tick();
        end
    endtask

    task automatic test_counter();
        for (int s = 0; s < 28; s++) begin
            if (s == 0)       drive(1, 0, 16'h0, 32'h0, 0, 0, 1);
            else if (s == 1)  drive(1, 1, 16'h0F0F, 32'h0000_F00D, 0, 0, 0);
            else if (s == 24) drive(1, 0, 16'h0, 32'h0, 0, 0, 1);
            else if (s < 26)  drive(1, 0, 16'h0, 32'h0, 0, 0, 0);
            else              drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL cnt_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            vectors++;
            if ((vc & mc) !== (ec & mc)) begin
                miscompares++; $display("FAIL cnt_c cyc=%0d got=%h want=%h", cyc, vc & mc, ec & mc);
            end
            if (s == 22 || s == 23) begin
                vectors++;
                if ({c_stall_cnt, a_stall_cnt} !== {4'd15, 16'(s - 2)}) begin
                    miscompares++;
                    $display("FAIL cnt_sat cyc=%0d got=%h want=%h", cyc, {c_stall_cnt, a_stall_cnt}, {4'd15, 16'(s - 2)});
                end
            end
            if (s == 25) begin
                vectors++;
                if ({c_stall_cnt, a_stall_cnt} !== 20'h0) begin
                    miscompares++; $display("FAIL cnt_clr cyc=%0d got=%h want=0", cyc, {c_stall_cnt, a_stall_cnt});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 7; s++) begin
            case (s)
                0:       drive(1, 1, 16'h7001, 32'h7000_0001, 0, 0, 0);
                1:       drive(1, 1, 16'h7002, 32'h7000_0002, 0, 0, 0);
                2:       drive(0, 1, 16'hFFFF, 32'h7000_0003, 0, 1, 1);
                3:       drive(0, 0, 16'h0, 32'h0, 0, 0, 0);
                4:       drive(1, 1, 16'h5A5A, 32'hD00D_0004, 0, 0, 0);
                default: drive(1, 0, 16'h0, 32'h0, 1, 0, 0);
            endcase
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL rmid_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            if (s == 2) begin
                vectors++;
                if ({a_occupancy, a_in_ready} !== {2'd2, 1'b0}) begin
                    miscompares++; $display("FAIL rmid_skid cyc=%0d got=%h want=%h", cyc, {a_occupancy, a_in_ready}, {2'd2, 1'b0});
                end
            end
            if (s == 3) begin
                vectors++;
                if (va !== 68'h0) begin
                    miscompares++; $display("FAIL rmid_zero cyc=%0d got=%h want=0", cyc, va);
                end
            end
            if (s == 4) begin
                vectors++;
                if (a_in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL rmid_rdy cyc=%0d got=%b want=1", cyc, a_in_ready);
                end
            end
            if (s == 5) begin
                vectors++;
                if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 16'h5A5A, 32'hD00D_0004}) begin
                    miscompares++;
                    $display("FAIL rmid_beat cyc=%0d got=%h want=%h", cyc, {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 16'h5A5A, 32'hD00D_0004});
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) != 0, 16'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0);
            vectors++;
            if ((va & ma) !== (ea & ma)) begin
                miscompares++; $display("FAIL rand_a cyc=%0d got=%h want=%h", cyc, va & ma, ea & ma);
            end
            vectors++;
            if ((vb & mb) !== (eb & mb)) begin
                miscompares++; $display("FAIL rand_b cyc=%0d got=%h want=%h", cyc, vb & mb, eb & mb);
            end
            vectors++;
            if ((vc & mc) !== (ec & mc)) begin
                miscompares++; $display("FAIL rand_c cyc=%0d got=%h want=%h", cyc, vc & mc, ec & mc);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid_off();
        test_counter();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
